// File: rtl/hazard_stall_ctrl.sv
// Producer-side hazard unit: shadows E/M/W register writes and raises stall when forwarding cannot meet Tuse.
// Optional HI/LO busy tracking is compiled in with `define HAZ_MDU_EN.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
`ifdef HAZ_MDU_EN
    input  logic       D_md_use,
    input  logic       D_md_start,
    input  logic       D_md_div,
    output logic       md_busy,
`endif
    input  logic [4:0] D_a1,
    input  logic [4:0] D_a2,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] D_a3,
    input  logic       D_we,
    input  logic [1:0] D_tnew,
    output logic       stall,
    output logic [4:0] E_a3,
    output logic       E_we,
    output logic [4:0] M_a3,
    output logic       M_we,
    output logic [4:0] W_a3,
    output logic       W_we,
    output logic [1:0] E_tnew,
    output logic [1:0] M_tnew
);

    localparam int unsigned TUSE_NONE = 3;
    localparam int unsigned MD_MAX    = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;

    if (CNT_W < int'($clog2(MD_MAX + 1))) begin : g_cnt_w_check
        $error("CNT_W too narrow for the MDU busy count");
    end

    logic rs_stall;
    logic rt_stall;
    logic md_stall;
    logic d_we_q;

    assign d_we_q = D_we && (D_a3 != 5'd0);

    // A source stalls when a producer in E or M will not have its result by the reader's Tuse.
    always_comb begin
        rs_stall = 1'b0;
        rt_stall = 1'b0;
        if ((D_a1 != 5'd0) && (D_tuse_rs != 2'(TUSE_NONE))) begin
            rs_stall = (E_we && (E_a3 == D_a1) && (E_tnew > D_tuse_rs)) ||
                       (M_we && (M_a3 == D_a1) && (M_tnew > D_tuse_rs));
        end
        if ((D_a2 != 5'd0) && (D_tuse_rt != 2'(TUSE_NONE))) begin
            rt_stall = (E_we && (E_a3 == D_a2) && (E_tnew > D_tuse_rt)) ||
                       (M_we && (M_a3 == D_a2) && (M_tnew > D_tuse_rt));
        end
    end

    assign stall = rs_stall || rt_stall || md_stall;

    // E captures D or a bubble; M and W shift unconditionally.
    always_ff @(posedge clk) begin
        if (reset) begin
            E_a3   <= 5'd0;
            E_we   <= 1'b0;
            E_tnew <= 2'd0;
            M_a3   <= 5'd0;
            M_we   <= 1'b0;
            M_tnew <= 2'd0;
            W_a3   <= 5'd0;
            W_we   <= 1'b0;
        end else begin
            if (stall) begin
                E_a3   <= 5'd0;
                E_we   <= 1'b0;
                E_tnew <= 2'd0;
            end else begin
                E_a3   <= d_we_q ? D_a3 : 5'd0;
                E_we   <= d_we_q;
                E_tnew <= d_we_q ? D_tnew : 2'd0;
            end
            M_a3   <= E_a3;
            M_we   <= E_we;
            M_tnew <= (E_tnew == 2'd0) ? 2'd0 : E_tnew - 2'd1;
            W_a3   <= M_a3;
            W_we   <= M_we;
        end
    end

`ifdef HAZ_MDU_EN
    logic             E_md_start;
    logic             E_md_div;
    logic [CNT_W-1:0] cnt;

    // Busy count loads as the mult/div leaves E and drains to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            E_md_start <= 1'b0;
            E_md_div   <= 1'b0;
            cnt        <= '0;
        end else begin
            E_md_start <= D_md_start && !stall;
            E_md_div   <= D_md_div && !stall;
            if (E_md_start) begin
                cnt <= E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign md_busy  = (cnt != '0);
    assign md_stall = D_md_use && (E_md_start || (cnt != '0));
`else
    assign md_stall = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed vector bench for hazard_stall_ctrl; MDU sequences run when HAZ_MDU_EN is defined.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_a1, D_a2, D_a3;
    logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
    logic       D_we;
    logic       stall;
    logic [4:0] E_a3, M_a3, W_a3;
    logic       E_we, M_we, W_we;
    logic [1:0] E_tnew, M_tnew;
`ifdef HAZ_MDU_EN
    logic       D_md_use, D_md_start, D_md_div, md_busy;
`endif

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk       (clk),
        .reset     (reset),
`ifdef HAZ_MDU_EN
        .D_md_use  (D_md_use),
        .D_md_start(D_md_start),
        .D_md_div  (D_md_div),
        .md_busy   (md_busy),
`endif
        .D_a1      (D_a1),
        .D_a2      (D_a2),
        .D_tuse_rs (D_tuse_rs),
        .D_tuse_rt (D_tuse_rt),
        .D_a3      (D_a3),
        .D_we      (D_we),
        .D_tnew    (D_tnew),
        .stall     (stall),
        .E_a3      (E_a3),
        .E_we      (E_we),
        .M_a3      (M_a3),
        .M_we      (M_we),
        .W_a3      (W_a3),
        .W_we      (W_we),
        .E_tnew    (E_tnew),
        .M_tnew    (M_tnew)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  a1;
        logic [1:0]  tr;
        logic [4:0]  a2;
        logic [1:0]  tt;
        logic [4:0]  a3;
        logic        we;
        logic [1:0]  tnew;
        logic        chk;
        logic        ex_stall;
        logic [21:0] ex_st;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    endtask

    function automatic logic [21:0] st(input logic [4:0] ea, input logic ew, input logic [1:0] et,
                                       input logic [4:0] ma, input logic mw, input logic [1:0] mt,
                                       input logic [4:0] wa, input logic ww);
        return {ea, ew, et, ma, mw, mt, wa, ww};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [4:0] a1, input logic [1:0] tr,
                                input logic [4:0] a2, input logic [1:0] tt, input logic [4:0] a3,
                                input logic we, input logic [1:0] tnew, input logic chk,
                                input logic ex_stall, input logic [21:0] ex_st);
        vec_t v;
        v.rst = rst; v.a1 = a1; v.tr = tr; v.a2 = a2; v.tt = tt;
        v.a3 = a3; v.we = we; v.tnew = tnew;
        v.chk = chk; v.ex_stall = ex_stall; v.ex_st = ex_st;
        return v;
    endfunction

    function automatic logic [21:0] dut_st();
        return {E_a3, E_we, E_tnew, M_a3, M_we, M_tnew, W_a3, W_we};
    endfunction

    task automatic drive(input logic [4:0] a1, input logic [1:0] tr, input logic [4:0] a2,
                         input logic [1:0] tt, input logic [4:0] a3, input logic we, input logic [1:0] tnew);
        D_a1 = a1; D_tuse_rs = tr; D_a2 = a2; D_tuse_rt = tt;
        D_a3 = a3; D_we = we; D_tnew = tnew;
    endtask

`ifdef HAZ_MDU_EN
    task automatic md_seq(input logic is_div, input int exp_cycles);
        int n;
        n = 0;
        @(negedge clk);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        D_md_start = 1'b1; D_md_div = is_div; D_md_use = 1'b1;
        @(negedge clk);
        D_md_start = 1'b0; D_md_div = 1'b0; D_md_use = 1'b1;
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 1'b1, 2'd1);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stall) break;
            n++;
            if (i == 1) check("md_busy_mid", int'(is_div), 32'(md_busy), 32'd1);
            @(negedge clk);
        end
        check("md_stall_len", int'(is_div), 32'(n), 32'(exp_cycles));
        check("md_busy_end", int'(is_div), 32'(md_busy), 32'd0);
        @(negedge clk);
        D_md_use = 1'b0;
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
    endtask
`endif

    initial begin
        reset = 1'b1;
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
`ifdef HAZ_MDU_EN
        D_md_use = 1'b0; D_md_start = 1'b0; D_md_div = 1'b0;
`endif

        // rst,   a1 tr  a2 tt  a3 we tnew  chk stall  expected E/M/W state before the edge
        vecs[0]  = mk(1, 0,3, 0,3, 0,0,0, 0,0, st(0,0,0, 0,0,0, 0,0));
        vecs[1]  = mk(0, 0,3, 0,3, 1,1,2, 1,0, st(0,0,0, 0,0,0, 0,0));   // lw $1
        vecs[2]  = mk(0, 1,1, 2,1, 3,1,1, 1,1, st(1,1,2, 0,0,0, 0,0));   // addu rs=$1: E hazard
        vecs[3]  = mk(0, 1,1, 2,1, 3,1,1, 1,0, st(0,0,0, 1,1,1, 0,0));   // M_tnew==tuse: clear
        vecs[4]  = mk(0, 0,3, 0,3, 0,0,0, 1,0, st(3,1,1, 0,0,0, 1,1));
        vecs[5]  = mk(0, 0,3, 0,3, 0,0,0, 1,0, st(0,0,0, 3,1,0, 0,0));
        vecs[6]  = mk(0, 0,3, 0,3, 0,0,0, 1,0, st(0,0,0, 0,0,0, 3,1));
        vecs[7]  = mk(0, 0,3, 0,3, 1,1,2, 1,0, st(0,0,0, 0,0,0, 0,0));   // lw $1
        vecs[8]  = mk(0, 1,0, 4,0, 0,0,0, 1,1, st(1,1,2, 0,0,0, 0,0));   // beq rs=$1
        vecs[9]  = mk(0, 1,0, 4,0, 0,0,0, 1,1, st(0,0,0, 1,1,1, 0,0));
        vecs[10] = mk(0, 1,0, 4,0, 0,0,0, 1,0, st(0,0,0, 0,0,0, 1,1));   // W never stalls
        vecs[11] = mk(0, 0,3, 0,3, 0,0,0, 1,0, st(0,0,0, 0,0,0, 0,0));
        vecs[12] = mk(0, 2,1, 3,1, 1,1,1, 1,0, st(0,0,0, 0,0,0, 0,0));   // addu $1
        vecs[13] = mk(0, 5,1, 1,2, 0,0,0, 1,0, st(1,1,1, 0,0,0, 0,0));   // sw rt=$1
        vecs[14] = mk(0, 0,3, 0,3, 0,0,0, 1,0, st(0,0,0, 1,1,0, 0,0));
        vecs[15] = mk(0, 0,3, 0,3, 0,1,2, 1,0, st(0,0,0, 0,0,0, 1,1));   // write to $0
        vecs[16] = mk(0, 0,0, 0,0, 0,0,0, 1,0, st(0,0,0, 0,0,0, 0,0));   // reader of $0
        vecs[17] = mk(0, 0,3, 0,3, 7,1,2, 1,0, st(0,0,0, 0,0,0, 0,0));   // lw $7
        vecs[18] = mk(0, 0,3, 0,3, 0,0,0, 1,0, st(7,1,2, 0,0,0, 0,0));
        vecs[19] = mk(0, 0,3, 7,0, 0,0,0, 1,1, st(0,0,0, 7,1,1, 0,0));   // rt hazard from M
        vecs[20] = mk(0, 0,3, 7,0, 0,0,0, 1,0, st(0,0,0, 0,0,0, 7,1));
        vecs[21] = mk(0, 0,3, 0,3, 0,0,0, 1,0, st(0,0,0, 0,0,0, 0,0));

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            drive(vecs[i].a1, vecs[i].tr, vecs[i].a2, vecs[i].tt, vecs[i].a3, vecs[i].we, vecs[i].tnew);
            #1;
            if (vecs[i].chk) begin
                check("vec_stall", i, 32'(stall), 32'(vecs[i].ex_stall));
                check("vec_state", i, 32'(dut_st()), 32'(vecs[i].ex_st));
            end
        end

        // Reset asserted during the first stall cycle of lw/beq.
        @(negedge clk);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 1'b1, 2'd2);
        @(negedge clk);
        drive(5'd1, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        #1;
        check("rst_pre_stall", 0, 32'(stall), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_stall", 0, 32'(stall), 32'd0);
        check("rst_mid_state", 0, 32'(dut_st()), 32'd0);
        @(negedge clk);
        #1;
        check("rst_after_stall", 1, 32'(stall), 32'd0);
        check("rst_after_state", 1, 32'(dut_st()), 32'd0);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);

`ifdef HAZ_MDU_EN
        md_seq(1'b0, 6);
        for (int i = 0; i < 3; i++) @(negedge clk);
        md_seq(1'b1, 11);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
